// File: rtl/huffman_act_canon.sv
// Canonical-Huffman activation decoder: serial bits in, BW-bit symbols packed NUM_WORDS per output word.
// Code-length/symbol tables are programmable while idle; overlong codes raise a sticky error.
module huffman_act_canon #(
    parameter int BW        = 4,
    parameter int NUM_WORDS = 8,
    parameter int MAX_LEN   = 11,
    localparam int NSYM = 2 ** BW,
    localparam int AW   = ($clog2(NSYM) > $clog2(MAX_LEN + 1)) ? $clog2(NSYM) : $clog2(MAX_LEN + 1),
    localparam int DW   = (BW > $clog2(NSYM) + 1) ? BW : $clog2(NSYM) + 1,
    localparam int OCW  = $clog2(NUM_WORDS + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_bit,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    flush,
    output logic [BW*NUM_WORDS-1:0] out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OCW-1:0]          out_count,
    output logic                    error,
    input  logic                    cfg_we,
    input  logic                    cfg_sel,
    input  logic [AW-1:0]           cfg_addr,
    input  logic [DW-1:0]           cfg_data,
    output logic                    cfg_ready
);

    localparam int CW  = MAX_LEN + 1;
    localparam int LW  = $clog2(MAX_LEN + 1);
    localparam int CTN = 2 ** LW;
    localparam int PW  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int OW  = BW * NUM_WORDS;

    localparam logic [PW-1:0] PTR_TOP  = PW'(NUM_WORDS - 1);
    localparam logic [LW-1:0] LAST_LEN = LW'(MAX_LEN - 1);

    // Default tables reproduce the legacy activation tree.
    function automatic logic [DW-1:0] default_count(input int l);
        case (l)
            1:                 return DW'(1);
            4:                 return DW'(7);
            5, 6, 7, 8, 9, 10: return DW'(1);
            11:                return DW'(2);
            default:           return DW'(0);
        endcase
    endfunction

    function automatic logic [BW-1:0] default_sym(input int i);
        case (i)
            11:      return BW'(12);
            12:      return BW'(11);
            13:      return BW'(15);
            14:      return BW'(13);
            15:      return BW'(14);
            default: return BW'(i);
        endcase
    endfunction

    logic [DW-1:0] count_tab [CTN];
    logic [BW-1:0] sym_tab   [NSYM];

    logic [LW-1:0] len;
    logic [CW-1:0] code;
    logic [CW-1:0] first;
    logic [CW-1:0] index;
    logic [OW-1:0] acc;
    logic [PW-1:0] ptr;

    logic          accept;
    logic [LW-1:0] len_inc;
    logic [CW-1:0] c;
    logic [CW-1:0] n_ext;
    logic [CW:0]   diff;
    logic          match;
    logic [BW-1:0] sym_pos;
    logic [BW-1:0] dec_sym;
    logic [OW-1:0] acc_new;
    logic          acc_empty;
    logic          word_done;
    logic          flush_go;
    logic [OCW-1:0] stored;

    assign in_ready  = !(out_valid && !out_ready && (ptr == '0));
    assign acc_empty = (ptr == PTR_TOP);
    assign cfg_ready = (len == '0) && acc_empty && !out_valid;
    assign accept    = in_valid && in_ready;

    // Code and first are kept pre-shifted, so the new bit simply fills the LSB.
    // A borrow out of the subtraction means c sits below this length's first code.
    always_comb begin
        len_inc = len + 1'b1;
        c       = code | CW'(in_bit);
        n_ext   = CW'(count_tab[len_inc]);
        diff    = {1'b0, c} - {1'b0, first};
        match   = !diff[CW] && (diff[CW-1:0] < n_ext);
        sym_pos = BW'(index + diff[CW-1:0]);
        dec_sym = sym_tab[sym_pos];
        acc_new = acc;
        acc_new[int'(ptr)*BW +: BW] = dec_sym;
    end

    assign word_done = accept && match && (ptr == '0);
    assign flush_go  = flush && !accept && (len == '0) && !acc_empty && (!out_valid || out_ready);
    assign stored    = OCW'(NUM_WORDS - 1) - OCW'(ptr);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < CTN; i++) count_tab[i] <= default_count(i);
            for (int i = 0; i < NSYM; i++) sym_tab[i] <= default_sym(i);
            len       <= '0;
            code      <= '0;
            first     <= '0;
            index     <= '0;
            acc       <= '0;
            ptr       <= PTR_TOP;
            out       <= '0;
            out_valid <= 1'b0;
            out_count <= '0;
            error     <= 1'b0;
        end else begin
            if (cfg_we && cfg_ready) begin
                if (!cfg_sel) begin
                    if ((cfg_addr != '0) && (cfg_addr <= AW'(MAX_LEN)))
                        count_tab[cfg_addr[LW-1:0]] <= cfg_data;
                end else if ({1'b0, cfg_addr} < (AW + 1)'(NSYM)) begin
                    sym_tab[cfg_addr[BW-1:0]] <= cfg_data[BW-1:0];
                end
            end

            if (accept) begin
                if (match) begin
                    len   <= '0;
                    code  <= '0;
                    first <= '0;
                    index <= '0;
                    if (ptr == '0) begin
                        out       <= acc_new;
                        out_count <= OCW'(NUM_WORDS);
                        out_valid <= 1'b1;
                        acc       <= '0;
                        ptr       <= PTR_TOP;
                    end else begin
                        acc <= acc_new;
                        ptr <= ptr - 1'b1;
                    end
                end else if (len == LAST_LEN) begin
                    error <= 1'b1;
                    len   <= '0;
                    code  <= '0;
                    first <= '0;
                    index <= '0;
                end else begin
                    index <= index + n_ext;
                    first <= (first + n_ext) << 1;
                    code  <= c << 1;
                    len   <= len_inc;
                end
            end else if (flush_go) begin
                out       <= acc;
                out_count <= stored;
                out_valid <= 1'b1;
                acc       <= '0;
                ptr       <= PTR_TOP;
            end

            if (out_valid && out_ready && !word_done && !flush_go)
                out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_huffman_act_canon.sv
// Scoreboarded bench for huffman_act_canon: prefix-matching reference decoder feeds expected words to a monitor.
module tb_huffman_act_canon;

    localparam int BW   = 4;
    localparam int NW   = 8;
    localparam int ML   = 11;
    localparam int NSYM = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_bit, in_valid, flush, out_ready, cfg_we, cfg_sel;
    logic [3:0]  cfg_addr;
    logic [4:0]  cfg_data;
    logic        in_ready, out_valid, error, cfg_ready;
    logic [31:0] out;
    logic [3:0]  out_count;

    huffman_act_canon #(.BW(BW), .NUM_WORDS(NW), .MAX_LEN(ML)) dut (
        .clk(clk), .reset(reset), .in_bit(in_bit), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .out(out), .out_valid(out_valid), .out_ready(out_ready),
        .out_count(out_count), .error(error), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_ready(cfg_ready)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int bp_mode  = 0;
    int gap_mode = 0;

    int dsym [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 12, 11, 15, 13, 14};
    int m_count [16];
    int m_sym   [16];
    int m_len   [16];
    int m_code  [16];
    int acc_syms [$];
    logic [31:0] exp_word [$];
    int exp_cnt [$];
    int cur_code, cur_len;
    logic exp_error;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Textbook canonical assignment: consecutive codes per length, shifted between lengths.
    task automatic build_codes();
        int cd = 0;
        int idx = 0;
        for (int i = 0; i < NSYM; i++) begin m_len[i] = 0; m_code[i] = 0; end
        for (int l = 1; l <= ML; l++) begin
            for (int k = 0; k < m_count[l]; k++) begin
                if (idx < NSYM) begin
                    m_len[idx]  = l;
                    m_code[idx] = cd;
                    idx++;
                end
                cd++;
            end
            cd = cd * 2;
        end
    endtask

    task automatic model_reset();
        for (int l = 0; l < 16; l++) m_count[l] = 0;
        m_count[1] = 1;
        m_count[4] = 7;
        for (int l = 5; l <= 10; l++) m_count[l] = 1;
        m_count[11] = 2;
        m_sym = dsym;
        build_codes();
        acc_syms.delete();
        exp_word.delete();
        exp_cnt.delete();
        cur_code  = 0;
        cur_len   = 0;
        exp_error = 1'b0;
    endtask

    task automatic push_word();
        logic [31:0] w = 32'h0;
        for (int k = 0; k < acc_syms.size(); k++)
            w = w | (32'(acc_syms[k] & 15) << ((NW - 1 - k) * BW));
        exp_word.push_back(w);
        exp_cnt.push_back(acc_syms.size());
        acc_syms.delete();
    endtask

    task automatic model_bit(input int b);
        int found = 0;
        int s = 0;
        cur_code = cur_code * 2 + b;
        cur_len++;
        for (int i = 0; i < NSYM; i++)
            if (found == 0 && m_len[i] == cur_len && m_code[i] == cur_code) begin
                found = 1;
                s = m_sym[i];
            end
        if (found != 0) begin
            acc_syms.push_back(s);
            if (acc_syms.size() == NW) push_word();
            cur_code = 0;
            cur_len  = 0;
        end else if (cur_len == ML) begin
            exp_error = 1'b1;
            cur_code  = 0;
            cur_len   = 0;
        end
    endtask

    task automatic send_bit(input int b);
        int waited = 0;
        in_valid = 1'b1;
        in_bit   = b[0];
        @(negedge clk);
        while (!in_ready && waited < 200) begin @(negedge clk); waited++; end
        if (!in_ready) begin
            checkOutput("in_ready_timeout", 0, 1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            model_bit(b);
        end
    endtask

    task automatic applyStimulus(input int s);
        int l = 0;
        int cd = 0;
        for (int i = NSYM - 1; i >= 0; i--)
            if (m_sym[i] == s && m_len[i] != 0) begin l = m_len[i]; cd = m_code[i]; end
        for (int k = l - 1; k >= 0; k--) begin
            if (gap_mode != 0 && $urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
            send_bit((cd >> k) & 1);
        end
    endtask

    task automatic doFlush();
        int waited = 0;
        flush = 1'b1;
        if (acc_syms.size() == 0) begin
            @(posedge clk); #1;
            flush = 1'b0;
        end else begin
            @(negedge clk);
            while (out_valid && !out_ready && waited < 300) begin @(negedge clk); waited++; end
            if (out_valid && !out_ready) begin
                checkOutput("flush_timeout", 0, 1);
                flush = 1'b0;
            end else begin
                @(posedge clk); #1;
                flush = 1'b0;
                push_word();
            end
        end
    endtask

    task automatic cfg_write(input int sel, input int addr, input int data);
        int waited = 0;
        cfg_sel = sel[0]; cfg_addr = addr[3:0]; cfg_data = data[4:0]; cfg_we = 1'b1;
        @(negedge clk);
        while (!cfg_ready && waited < 300) begin @(negedge clk); waited++; end
        checkOutput("cfg_ready_wait", cfg_ready, 1);
        @(posedge clk); #1;
        cfg_we = 1'b0;
        if (sel == 0 && addr >= 1 && addr <= ML) m_count[addr] = data;
        else if (sel != 0) m_sym[addr] = data & 15;
        build_codes();
    endtask

    task automatic cfg_try(input int sel, input int addr, input int data);
        cfg_sel = sel[0]; cfg_addr = addr[3:0]; cfg_data = data[4:0]; cfg_we = 1'b1;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic doReset();
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; cfg_we = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_word.size() != 0 || out_valid) && n < 1000) begin @(posedge clk); #1; n++; end
        checkOutput("drain_queue", exp_word.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        checkOutput({tag, "_out"}, out, 0);
        checkOutput({tag, "_out_valid"}, out_valid, 0);
        checkOutput({tag, "_out_count"}, out_count, 0);
        checkOutput({tag, "_error"}, error, 0);
        checkOutput({tag, "_in_ready"}, in_ready, 1);
        checkOutput({tag, "_cfg_ready"}, cfg_ready, 1);
    endtask

    // out_ready moves just after each edge so a negedge sample predicts the next handshake.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #2;
            case (bp_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready) begin
                if (exp_word.size() == 0) begin
                    checkOutput("unexpected_word", {32'h0, out}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    checkOutput("word", out, exp_word.pop_front());
                    checkOutput("word_count", out_count, exp_cnt.pop_front());
                end
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog expired before end of test");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        in_bit = 1'b0; in_valid = 1'b0; flush = 1'b0;
        cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_data = '0;
        doReset();
        check_reset_outputs("reset");

        $display("[TB] eight zero-length-1 codes");
        for (int i = 0; i < 7; i++) send_bit(0);
        checkOutput("t1_valid_before_last", out_valid, 0);
        send_bit(0);
        checkOutput("t1_latency", out_valid, 1);

        $display("[TB] symbols 1..8");
        for (int s = 1; s <= 8; s++) applyStimulus(s);
        checkOutput("t2_out", out, 32'h1234_5678);

        $display("[TB] backpressure");
        repeat (2) @(posedge clk);
        #1 bp_mode = 1;
        @(posedge clk); #1;
        for (int i = 0; i < 15; i++) applyStimulus(0);
        @(negedge clk);
        checkOutput("t3_in_ready_low", in_ready, 0);
        checkOutput("t3_out_valid_held", out_valid, 1);
        fork
            send_bit(0);
            begin repeat (4) @(posedge clk); #1 bp_mode = 0; end
        join
        wait_drain();

        $display("[TB] long codes and flush");
        applyStimulus(13); applyStimulus(14); applyStimulus(15);
        doFlush();
        checkOutput("t4_out", out, 32'hDEF0_0000);
        checkOutput("t4_count", out_count, 3);
        wait_drain();
        doFlush();
        checkOutput("empty_flush_valid", out_valid, 0);

        $display("[TB] random traffic");
        bp_mode = 2; gap_mode = 1;
        repeat (120) begin
            applyStimulus($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) doFlush();
        end
        doFlush();
        bp_mode = 0; gap_mode = 0;
        wait_drain();

        $display("[TB] overlong code");
        cfg_write(0, 1, 1);
        for (int l = 4; l <= ML; l++) cfg_write(0, l, 0);
        for (int i = 0; i < 10; i++) send_bit(1);
        checkOutput("t5_error_before_max", error, exp_error);
        send_bit(1);
        checkOutput("t5_error_at_max", error, exp_error);
        send_bit(0);
        doFlush();
        checkOutput("t5_sym0_out", out, 32'h0);
        checkOutput("t5_sym0_count", out_count, 1);
        checkOutput("t5_error_sticky", error, 1);
        wait_drain();

        $display("[TB] reset mid-operation");
        cfg_write(1, 0, 5);
        bp_mode = 1;
        @(posedge clk); #1;
        for (int i = 0; i < 9; i++) send_bit(0);
        send_bit(1); send_bit(1);
        checkOutput("pre_reset_out", out, 32'h5555_5555);
        checkOutput("pre_reset_valid", out_valid, 1);
        doReset();
        bp_mode = 0;
        check_reset_outputs("midreset");

        $display("[TB] config ignored while busy");
        send_bit(1);
        checkOutput("t6_cfg_busy", cfg_ready, 0);
        cfg_try(0, 4, 0);
        cfg_try(1, 1, 9);
        for (int i = 0; i < 3; i++) send_bit(0);
        doFlush();
        checkOutput("t6_out", out, 32'h1000_0000);
        checkOutput("t6_count", out_count, 1);
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
